// File: rtl/layer_serializer_if.sv
// Bus between an upstream neuron layer, the serializer and the next layer.
// master: the side that drives neuron words/valids/clear and observes the stream.
// slave : the serializer itself.
interface layer_serializer_if #(
  parameter int numNeurons = 32,
  parameter int dataWidth  = 8
);
  localparam int idxWidth = $clog2(numNeurons);

  logic [numNeurons*dataWidth-1:0] neuronOuts;
  logic [numNeurons-1:0]           neuronOutValids;
  logic                            layerClear;
  logic [dataWidth-1:0]            dataOut;
  logic                            dataValid;
  logic                            busy;
  logic                            done;
  logic [idxWidth-1:0]             argmaxIdx;
  logic                            argmaxValid;

  modport master (
    output neuronOuts, neuronOutValids, layerClear,
    input  dataOut, dataValid, busy, done, argmaxIdx, argmaxValid
  );

  modport slave (
    input  neuronOuts, neuronOutValids, layerClear,
    output dataOut, dataValid, busy, done, argmaxIdx, argmaxValid
  );
endinterface

// File: rtl/layer_serializer.sv
// layer_serializer: captures one word per neuron (first valid wins), then
// streams all captured words in index order, one per cycle, to the next layer.
// Optional feature macro SERIALIZER_ARGMAX_EN: tracks the index of the largest
// streamed word (unsigned, ties to lowest index); without it argmax ports are 0.
module layer_serializer #(
  parameter int numNeurons = 32,
  parameter int dataWidth  = 8
) (
  input logic               clk,
  input logic               reset,
  layer_serializer_if.slave bus
);
  localparam int idxWidth = $clog2(numNeurons);
  localparam int cntWidth = idxWidth + 1;
  localparam logic [cntWidth-1:0] LAST = cntWidth'(numNeurons);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_STREAM, S_DONE} state_e;

  state_e                               state_q, state_d;
  logic [numNeurons-1:0]                mask_q, mask_d;
  logic [numNeurons-1:0][dataWidth-1:0] word_q, word_d;
  logic [cntWidth-1:0]                  cnt_q, cnt_d;
  logic [dataWidth-1:0]                 data_q, data_d;
  logic                                 valid_q, valid_d;
  logic                                 done_q, done_d;
  logic                                 cap_en;
  logic [dataWidth-1:0]                 cur_word;

  // cnt_q indexes the next element to emit; LAST means all have been emitted
  assign cur_word = word_q[cnt_q[idxWidth-1:0]];
  // Clear wins over capture at the same edge
  assign cap_en   = (state_q == S_IDLE || state_q == S_CAPTURE) && !bus.layerClear;

  // Next-state, capture and stream datapath
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    for (int i = 0; i < numNeurons; i++) begin
      if (cap_en && bus.neuronOutValids[i] && !mask_q[i]) begin
        word_d[i] = bus.neuronOuts[i*dataWidth +: dataWidth];
        mask_d[i] = 1'b1;
      end
    end
    case (state_q)
      S_IDLE: if (|bus.neuronOutValids) state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (&mask_q) begin
          state_d = S_STREAM;
          data_d  = word_q[0];
          valid_d = 1'b1;
          cnt_d   = cntWidth'(1);
        end
      end
      S_STREAM: begin
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end else begin
          data_d = cur_word;
          cnt_d  = cnt_q + cntWidth'(1);
        end
      end
      default: ;
    endcase
    if (bus.layerClear) begin
      state_d = S_IDLE;
      mask_d  = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  // Control/output registers; reset overrides everything including clear
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Capture buffer needs no reset: the mask alone says what is meaningful
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign bus.dataOut   = data_q;
  assign bus.dataValid = valid_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q == S_CAPTURE) || (state_q == S_STREAM);

`ifdef SERIALIZER_ARGMAX_EN
  logic [dataWidth-1:0] max_q, max_d;
  logic [idxWidth-1:0]  idx_q, idx_d;

  // Running maximum over emitted elements; strict compare keeps lowest index on ties
  always_comb begin
    max_d = max_q;
    idx_d = idx_q;
    if (state_q == S_CAPTURE && &mask_q) begin
      max_d = word_q[0];
      idx_d = '0;
    end else if (state_q == S_STREAM && cnt_q != LAST && cur_word > max_q) begin
      max_d = cur_word;
      idx_d = cnt_q[idxWidth-1:0];
    end
  end

  // Argmax registers
  always_ff @(posedge clk) begin
    if (reset) begin
      max_q <= '0;
      idx_q <= '0;
    end else begin
      max_q <= max_d;
      idx_q <= idx_d;
    end
  end

  assign bus.argmaxIdx   = idx_q;
  assign bus.argmaxValid = (state_q == S_DONE);
`else
  assign bus.argmaxIdx   = '0;
  assign bus.argmaxValid = 1'b0;
`endif
endmodule

// File: tb/tb_layer_serializer.sv
// Bench for layer_serializer (numNeurons=4, dataWidth=8). Expected stream timing
// and contents are derived from each neuron's arrival cycle and word.
module tb_layer_serializer;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;
`ifdef SERIALIZER_ARGMAX_EN
  localparam bit AM = 1'b1;
`else
  localparam bit AM = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  layer_serializer_if #(.numNeurons(N), .dataWidth(W)) bus ();
  layer_serializer #(.numNeurons(N), .dataWidth(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [N-1:0][W-1:0] w;
    logic [N-1:0][3:0]   arr;
    logic [IW-1:0]       exp_idx;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, c, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int w0, w1, w2, w3, a0, a1, a2, a3, idx);
    vec_t v;
    v.w   = {W'(w3), W'(w2), W'(w1), W'(w0)};
    v.arr = {4'(a3), 4'(a2), 4'(a1), 4'(a0)};
    v.exp_idx = IW'(idx);
    return v;
  endfunction

  // Applies an arrival schedule (valids stay high once raised), checks the whole
  // stream, 20 held-valid cycles in DONE, then a clear with valids still high.
  task automatic run_sched(input vec_t v);
    int e = 0;
    int mn = 99;
    for (int i = 0; i < N; i++) begin
      if (int'(v.arr[i]) > e)  e  = int'(v.arr[i]);
      if (int'(v.arr[i]) < mn) mn = int'(v.arr[i]);
    end
    bus.layerClear = 1'b0;
    for (int c = 0; c <= e + N + 21; c++) begin
      for (int i = 0; i < N; i++) begin
        bus.neuronOutValids[i] = (c >= int'(v.arr[i]));
        bus.neuronOuts[i*W +: W] = (c == int'(v.arr[i])) ? v.w[i] : W'($urandom);
      end
      tick();
      chk("dataValid", c, 32'(bus.dataValid), 32'(c >= e + 1 && c <= e + N));
      chk("busy", c, 32'(bus.busy), 32'(c >= mn && c <= e + N));
      chk("done", c, 32'(bus.done), 32'(c == e + N + 1));
      chk("argmaxValid", c, 32'(bus.argmaxValid), 32'(AM && c >= e + N + 1));
      if (c >= e + 1)
        chk("dataOut", c, 32'(bus.dataOut), 32'(v.w[(c - e - 1 < N) ? c - e - 1 : N - 1]));
      if (!AM)
        chk("argmaxIdx_off", c, 32'(bus.argmaxIdx), 32'(0));
      else if (c >= e + N + 1)
        chk("argmaxIdx", c, 32'(bus.argmaxIdx), 32'(v.exp_idx));
    end
    bus.layerClear = 1'b1;
    bus.neuronOutValids = '1;
    tick();
    chk("clr_busy", 0, 32'(bus.busy), 32'(0));
    chk("clr_dataValid", 0, 32'(bus.dataValid), 32'(0));
    chk("clr_done", 0, 32'(bus.done), 32'(0));
    chk("clr_argmaxValid", 0, 32'(bus.argmaxValid), 32'(0));
    bus.layerClear = 1'b0;
  endtask

  vec_t tbl[5];

  initial begin
    // words / arrival cycles per neuron / expected argmax
    tbl[0] = mk(3, 9, 9, 1,         0, 0, 0, 0, 1);
    tbl[1] = mk(10, 20, 30, 40,     3, 9, 0, 5, 3);
    tbl[2] = mk(0, 255, 7, 255,     0, 1, 2, 0, 1);
    tbl[3] = mk(5, 5, 5, 5,         0, 0, 0, 0, 0);
    tbl[4] = mk(200, 1, 250, 249,   2, 2, 2, 2, 2);

    // Reset beats clear and valids
    reset = 1'b1;
    bus.layerClear = 1'b1;
    bus.neuronOutValids = '1;
    bus.neuronOuts = '1;
    tick();
    tick();
    chk("rst_dataOut", 0, 32'(bus.dataOut), 32'(0));
    chk("rst_dataValid", 0, 32'(bus.dataValid), 32'(0));
    chk("rst_busy", 0, 32'(bus.busy), 32'(0));
    chk("rst_done", 0, 32'(bus.done), 32'(0));
    chk("rst_argmaxIdx", 0, 32'(bus.argmaxIdx), 32'(0));
    chk("rst_argmaxValid", 0, 32'(bus.argmaxValid), 32'(0));
    reset = 1'b0;
    bus.layerClear = 1'b0;
    bus.neuronOutValids = '0;
    tick();
    chk("idle_busy", 0, 32'(bus.busy), 32'(0));

    // Table vectors; tbl[3] follows a clear taken with valids high
    for (int t = 0; t < 5; t++) run_sched(tbl[t]);

    // Reset mid-capture with neurons 0 and 2 latched
    bus.neuronOutValids = 4'b0101;
    bus.neuronOuts = {8'd77, 8'd66, 8'd55, 8'd44};
    tick();
    chk("cap_busy", 0, 32'(bus.busy), 32'(1));
    bus.neuronOutValids = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_dataOut", 0, 32'(bus.dataOut), 32'(0));
    chk("rst2_busy", 0, 32'(bus.busy), 32'(0));
    chk("rst2_dataValid", 0, 32'(bus.dataValid), 32'(0));
    chk("rst2_argmaxIdx", 0, 32'(bus.argmaxIdx), 32'(0));
    run_sched(mk(12, 34, 56, 78, 3, 0, 3, 1, 3));

    // Clear while the second element is on dataOut
    bus.neuronOuts = {8'd44, 8'd33, 8'd22, 8'd11};
    bus.neuronOutValids = '1;
    tick();
    bus.neuronOutValids = '0;
    tick();
    chk("trunc_beat0", 1, 32'({bus.dataValid, bus.dataOut}), 32'({1'b1, 8'd11}));
    tick();
    chk("trunc_beat1", 2, 32'({bus.dataValid, bus.dataOut}), 32'({1'b1, 8'd22}));
    bus.layerClear = 1'b1;
    tick();
    bus.layerClear = 1'b0;
    chk("trunc_dataValid", 3, 32'(bus.dataValid), 32'(0));
    chk("trunc_busy", 3, 32'(bus.busy), 32'(0));
    for (int c = 4; c < 10; c++) begin
      tick();
      chk("trunc_nodone", c, 32'({bus.done, bus.dataValid, bus.busy}), 32'(0));
    end
    run_sched(mk(101, 102, 103, 100, 1, 0, 2, 0, 2));

    // Randomized schedules; expected argmax is first index of the maximum
    for (int r = 0; r < 20; r++) begin
      vec_t v;
      int best;
      for (int i = 0; i < N; i++) begin
        v.w[i]   = W'($urandom_range(0, 255));
        v.arr[i] = 4'($urandom_range(0, 7));
      end
      if (r % 4 == 0) v.w[3] = v.w[1];
      best = 0;
      for (int i = 1; i < N; i++) if (v.w[i] > v.w[best]) best = i;
      v.exp_idx = IW'(best);
      run_sched(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/layer_serializer.md
LAYER_SERIALIZER -- requirements
Module: layer_serializer

Interface
REQ-001 SHALL have parameter numNeurons, default 32: neurons in the upstream layer; legal range 2..1024.
REQ-002 SHALL have parameter dataWidth, default 8: width of each neuron output word.
REQ-003 SHALL derive localparam idxWidth = $clog2(numNeurons).
REQ-004 Ports SHALL be: clk  input  1  clock, all logic on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 neuronOuts  input  numNeurons*dataWidth  packed outputs; neuron i at bits [i*dataWidth +: dataWidth].
REQ-007 neuronOutValids  input  numNeurons  per-neuron valid; a neuron may hold it high for many cycles.
REQ-008 layerClear  input  1  releases DONE or aborts any operation; re-arms capture.
REQ-009 dataOut  output  dataWidth  serial word to the next layer's neuronIn.
REQ-010 dataValid  output  1  high while dataOut carries a stream element; drives the next layer's neuronValid.
REQ-011 busy  output  1  high in CAPTURE and STREAM.
REQ-012 done  output  1  one-cycle pulse after the last element.
REQ-013 argmaxIdx  output  idxWidth  index of the largest captured word.
REQ-014 argmaxValid  output  1  high with done and throughout DONE.

Function
REQ-015 FSM states SHALL be IDLE, CAPTURE, STREAM, DONE; encoding is free.
REQ-016 Capture mask: in IDLE or CAPTURE, at each edge with neuronOutValids[i]=1 and mask[i]=0, buf[i] SHALL load word i and mask[i] SHALL set; words with mask[i]=1 are not reloaded.
REQ-017 IDLE->CAPTURE SHALL occur on the first edge where any valid is sampled; busy=1 from that edge.
REQ-018 CAPTURE->STREAM SHALL occur on the edge after the mask becomes all ones (edge E+1 if the last valid was sampled at edge E); if all valids arrive at one edge, the IDLE->CAPTURE->STREAM path still applies.
REQ-019 Element k (buf[k], k=0..numNeurons-1) SHALL be registered onto dataOut at edge E+1+k with dataValid=1: exactly numNeurons consecutive beats, no gaps, no backpressure.
REQ-020 At edge E+1+numNeurons: dataValid SHALL go 0, done=1 for exactly one cycle, state SHALL become DONE, busy=0.
REQ-021 dataOut SHALL hold the last element while dataValid=0.
REQ-022 In STREAM and DONE, neuronOutValids SHALL be ignored.
REQ-023 DONE SHALL persist until layerClear; then IDLE with mask cleared.
REQ-024 layerClear in any state SHALL, at that edge, force IDLE, clear mask, dataValid=0, busy=0, done=0, argmaxValid=0; valids sampled at that edge are NOT captured (clear wins).
REQ-025 Mid-stream clear SHALL truncate the stream without asserting done.

Reset
REQ-026 reset SHALL force state IDLE, mask 0, dataOut 0, dataValid 0, busy 0, done 0, argmaxIdx 0, argmaxValid 0; buf contents are don't-care.
REQ-027 reset SHALL take priority over layerClear and all other inputs.

Configuration
REQ-028 With macro SERIALIZER_ARGMAX_EN defined: during STREAM the block SHALL track the largest word as unsigned, ties to the lowest index; argmaxIdx is valid when done=1 and held through DONE with argmaxValid=1.
REQ-029 Without SERIALIZER_ARGMAX_EN: argmaxIdx and argmaxValid ports SHALL exist and be tied to 0; no comparator logic.

Verification
REQ-030 numNeurons=4, all valids together at edge E with words 3,9,9,1 -> dataValid at E+1..E+4 carrying 3,9,9,1; done at E+5; argmaxIdx=1 (macro on).
REQ-031 Valids staggered: neuron 2 at E0, 0 at E0+3, 3 at E0+5, 1 at E0+9, each held high afterwards -> first beat at E0+10; words are those sampled at the first valid edge per neuron.
REQ-032 layerClear at the 2nd stream beat -> dataValid=0 next cycle, no done; a new capture after clear streams fresh data.
REQ-033 DONE with valids held high for 20 cycles -> no new stream; layerClear then recaptures at the next edge and streams again.
REQ-034 reset asserted in CAPTURE with mask partially set -> all outputs 0, mask 0; a full capture afterwards streams correctly.
REQ-035 Macro off -> argmaxIdx=0 and argmaxValid=0 through a full stream with words 0,255,7,255.
